// File: rtl/sram_req_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter_if
// Brief    : sram-like request/response bundle shared by requesters and memory
// Revision : 1.0 - initial release
// ============================================================================
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  // master issues requests, slave accepts them and returns responses
  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_req_arbiter
// Brief    : Shares one sram-like port between fetch and data paths, one
//            transaction outstanding; ARB_FLUSH_EN adds flush/discard support.
// Revision : 1.0 - initial release
// ============================================================================
module sram_req_arbiter (
  input  logic               clk,
  input  logic               resetn,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master mem
`ifdef ARB_FLUSH_EN
  ,
  input  logic               flush
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] C_STARVE_MAX = 2'd3;
  localparam logic [1:0] C_SIZE_WORD  = 2'd2;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_starve;
  logic        r_owner_inst;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;

  logic w_grant_inst;
  logic w_grant_data;
  logic w_resp_done;
  logic w_inst_allowed;
  logic w_discard_now;
  logic w_inst_data_ok;
  logic w_data_data_ok;
  logic w_inst_fields_unused;

  // fetch is read-only word access; its write-side fields are never used
  assign w_inst_fields_unused = ^{inst.wr, inst.size, inst.wstrb, inst.wdata};

`ifdef ARB_FLUSH_EN
  logic r_discard;
  logic w_flush_inst;

  assign w_flush_inst   = flush && r_owner_inst && (r_state != S_IDLE);
  assign w_inst_allowed = !flush;
  // a flush in the response cycle itself already suppresses that response
  assign w_discard_now  = r_discard || w_flush_inst;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_discard <= 1'b0;
    end else if (w_resp_done) begin
      r_discard <= 1'b0;
    end else if (w_flush_inst) begin
      r_discard <= 1'b1;
    end
  end
`else
  assign w_inst_allowed = 1'b1;
  assign w_discard_now  = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_resp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        // grants are gated by resetn so addr_ok stays low while in reset
        w_grant_inst = resetn && inst.req && w_inst_allowed &&
                       (!data.req || (r_starve == C_STARVE_MAX));
        w_grant_data = resetn && data.req && !w_grant_inst;
        if (w_grant_inst || w_grant_data) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (mem.addr_ok) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (mem.data_ok) begin
          w_resp_done  = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve     <= 2'd0;
      r_owner_inst <= 1'b0;
      r_wr         <= 1'b0;
      r_size       <= 2'd0;
      r_addr       <= 32'd0;
      r_wstrb      <= 4'd0;
      r_wdata      <= 32'd0;
    end else if (w_grant_inst) begin
      r_starve     <= 2'd0;
      r_owner_inst <= 1'b1;
      r_wr         <= 1'b0;
      r_size       <= C_SIZE_WORD;
      r_addr       <= inst.addr;
      r_wstrb      <= 4'd0;
      r_wdata      <= 32'd0;
    end else if (w_grant_data) begin
      if (inst.req && (r_starve != C_STARVE_MAX)) begin
        r_starve <= r_starve + 2'd1;
      end
      r_owner_inst <= 1'b0;
      r_wr         <= data.wr;
      r_size       <= data.size;
      r_addr       <= data.addr;
      r_wstrb      <= data.wstrb;
      r_wdata      <= data.wdata;
    end
  end

  assign w_inst_data_ok = w_resp_done && r_owner_inst && !w_discard_now;
  assign w_data_data_ok = w_resp_done && !r_owner_inst;

  assign inst.addr_ok = w_grant_inst;
  assign inst.data_ok = w_inst_data_ok;
  assign inst.rdata   = w_inst_data_ok ? mem.rdata : 32'd0;
  assign data.addr_ok = w_grant_data;
  assign data.data_ok = w_data_data_ok;
  assign data.rdata   = w_data_data_ok ? mem.rdata : 32'd0;

  assign mem.req   = (r_state == S_REQ);
  assign mem.wr    = r_wr;
  assign mem.size  = r_size;
  assign mem.addr  = r_addr;
  assign mem.wstrb = r_wstrb;
  assign mem.wdata = r_wdata;

endmodule
`default_nettype wire

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Two-requester arbiter that shares one sram-like memory port between the instruction-fetch path (preIF/IF) and the data-access path (EX/MEM). Latches one winning request, drives it onto the shared port, and tracks it until its response returns. Routes read data back to the owner. Exactly one transaction is outstanding at a time. Sits between the pipeline stages and the single memory/bridge interface.

## Interface
No parameters. Data width is fixed at 32 bits.

Ports:
- clk  in  1  core clock; all state on rising edge
- resetn  in  1  reset, asynchronous and active-low
- inst_req  in  1  fetch request (read only)
- inst_addr  in  32  fetch address
- inst_addr_ok  out  1  fetch request accepted (1-cycle pulse)
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  32  fetch data, valid with inst_data_ok
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  32  data address
- data_wstrb  in  4  byte strobes
- data_wdata  in  32  write data
- data_addr_ok  out  1  data request accepted (1-cycle pulse)
- data_data_ok  out  1  data response (1-cycle pulse; also completes writes)
- data_rdata  out  32  read data, valid with data_data_ok
- mem_req, mem_wr, mem_size[2], mem_addr[32], mem_wstrb[4], mem_wdata[32]  out  shared request, registered
- mem_addr_ok  in  1  shared port accepted request
- mem_data_ok  in  1  shared port response
- mem_rdata  in  32  shared read data
- flush  in  1  pipeline flush; present only with ARB_FLUSH_EN

## Operation
- State machine: IDLE, REQ, RESP.
- **IDLE**
  - If any request is pending, pick a winner.
  - Pulse the winner's *_addr_ok combinationally.
  - Latch owner, wr, size, addr, wstrb, wdata. Move to REQ.
  - Inst requests always latch wr=0, size=2, wstrb=0.
- **REQ**
  - mem_req=1; mem_* come from the latched fields.
  - On mem_addr_ok, move to RESP. mem_data_ok is ignored in this state.
- **RESP**
  - mem_req=0.
  - On mem_data_ok, pulse the owner's *_data_ok in the same cycle.
  - Drive *_rdata = mem_rdata combinationally. Move to IDLE.
- Requests are never accepted in REQ or RESP. Requesters hold req/fields until they see *_addr_ok.
- **Priority:** data beats inst.
  - A 2-bit starve counter counts IDLE grants given to data while inst_req=1.
  - When the counter reaches 3, the next grant goes to inst if inst_req=1.
  - Any inst grant clears the counter. The counter saturates at 3.
- Non-owner *_data_ok stays 0. *_rdata drives 0 when its data_ok=0.

## Timing
- Reset: state=IDLE, starve=0, owner=data, discard=0.
  - All latched fields are 0.
  - All outputs are 0: mem_req, mem_*, *_addr_ok, *_data_ok, *_rdata.
- Requester addr_ok arrives in the same cycle T as a pending req while IDLE.
- mem_req is asserted from T+1.
- With zero-wait memory (mem_addr_ok at T+1, mem_data_ok at T+2), the requester sees data_ok at T+2.
- Back-to-back: after data_ok at cycle D, the next addr_ok is at D+1 at the earliest.
- Asynchronous reset mid-transaction abandons it. No response is generated afterwards.
- Both requests pending with starve<3: data wins and inst stays pending.

## Configuration
- Macro: ARB_FLUSH_EN.
- **Defined:** the flush port exists.
  - flush=1 in IDLE blocks an inst grant that cycle (data may still be granted).
  - flush=1 in REQ or RESP while owner=inst sets discard.
  - The inst transaction still completes on the mem side, but inst_data_ok is suppressed.
  - discard clears on that mem_data_ok.
  - Data transactions are never affected.
- **Undefined:** no flush port, no discard logic. Every inst response is delivered.

## Test plan
- **Single inst read:** inst_req=1, inst_addr=0x1c000000 at T; zero-wait mem returns 0x02800000.
  - inst_addr_ok at T; mem_req at T+1 with addr 0x1c000000 and wr=0.
  - inst_data_ok at T+2 with inst_rdata=0x02800000.
- **Data write:** data_req=1, wr=1, size=2, addr=0x1c008000, wstrb=0xF, wdata=0xDEADBEEF.
  - mem_* carry exactly these values until mem_addr_ok.
  - data_data_ok pulses on mem_data_ok.
  - inst_data_ok stays 0 throughout.
- **Contention and starvation:** inst_req and data_req held high continuously, zero-wait mem.
  - Grant order is D, D, D, I, D, D, D, I.
  - The counter returns to 0 after each I.
- **Stalled memory:** mem_addr_ok delayed 4 cycles, then mem_data_ok delayed 3 cycles.
  - mem_req is held 4 cycles with stable fields.
  - No new addr_ok is issued until after data_ok.
- **Async reset:** resetn falls mid-RESP.
  - All outputs go to 0 immediately.
  - A mem_data_ok arriving after release produces no *_data_ok.
- **ARB_FLUSH_EN flush:** flush pulsed during an inst RESP.
  - mem_data_ok arrives but inst_data_ok stays 0.
  - The following inst request completes normally.
